// File: rtl/cardinal_cmp_top.sv
// Four-node 64-bit chip multiprocessor with per-node instruction and data memories.
// Nodes are identical, independent in-order cores; vectors are big-endian (bit 0 = MSB).

module imem (
    input  logic [0:7]  memAddr,
    output logic [0:31] dataOut
);
    logic [0:31] MEM [0:255];

    assign dataOut = MEM[memAddr];
endmodule

module dmem (
    input  logic        clk,
    input  logic        memEn,
    input  logic        memWrEn,
    input  logic [0:7]  memAddr,
    input  logic [0:63] dataIn,
    output logic [0:63] dataOut
);
    logic [0:63] MEM [0:255];

    always_ff @(posedge clk) begin
        if (memEn) begin
            if (memWrEn) MEM[memAddr] <= dataIn;
            else         dataOut      <= MEM[memAddr];
        end
    end
endmodule

module cardinal_node (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [0:31] inst_in,
    input  logic [0:63] d_in,
    output logic [0:31] pc_out,
    output logic [0:31] addr_out,
    output logic [0:63] d_out,
    output logic        mem_en,
    output logic        mem_wr_en
);
    localparam logic [0:5] OP_RTYPE = 6'b101010;
    localparam logic [0:5] OP_LD    = 6'b100000;
    localparam logic [0:5] OP_SD    = 6'b100001;
    localparam logic [0:5] OP_BEZ   = 6'b100010;
    localparam logic [0:5] OP_BNEZ  = 6'b100011;

    localparam logic [0:5] FN_AND = 6'd1;
    localparam logic [0:5] FN_OR  = 6'd2;
    localparam logic [0:5] FN_XOR = 6'd3;
    localparam logic [0:5] FN_NOT = 6'd4;
    localparam logic [0:5] FN_MOV = 6'd5;
    localparam logic [0:5] FN_ADD = 6'd6;
    localparam logic [0:5] FN_SUB = 6'd7;

    typedef enum logic {ST_EXEC, ST_LD_WAIT} state_t;

    state_t      state;
    logic [0:31] pc;
    logic [0:63] rf [0:31];

    logic [0:5]  opcode;
    logic [0:4]  rd;
    logic [0:4]  ra;
    logic [0:4]  rb;
    logic [0:5]  func;
    logic [0:15] imm16;
    logic [0:63] rd_val;
    logic [0:63] ra_val;
    logic [0:63] rb_val;

    logic        is_ld;
    logic        is_sd;
    logic        ld_pending;
    logic        taken;
    logic [0:31] pc_next;
    logic        alu_we;
    logic [0:63] alu_res;

    assign opcode = inst_in[0:5];
    assign rd     = inst_in[6:10];
    assign ra     = inst_in[11:15];
    assign rb     = inst_in[16:20];
    assign func   = inst_in[26:31];
    assign imm16  = inst_in[16:31];

    assign rd_val = rf[rd];
    assign ra_val = rf[ra];
    assign rb_val = rf[rb];

    assign is_ld      = (opcode == OP_LD);
    assign is_sd      = (opcode == OP_SD);
    assign ld_pending = (state == ST_LD_WAIT);

    assign taken   = ((opcode == OP_BEZ)  && (rd_val == '0)) ||
                     ((opcode == OP_BNEZ) && (rd_val != '0));
    assign pc_next = taken ? {16'h0000, imm16} : pc + 32'd4;

    always_comb begin
        alu_we  = 1'b0;
        alu_res = '0;
        if (opcode == OP_RTYPE) begin
            alu_we = 1'b1;
            case (func)
                FN_AND:  alu_res = ra_val & rb_val;
                FN_OR:   alu_res = ra_val | rb_val;
                FN_XOR:  alu_res = ra_val ^ rb_val;
                FN_NOT:  alu_res = ~ra_val;
                FN_MOV:  alu_res = ra_val;
                FN_ADD:  alu_res = ra_val + rb_val;
                FN_SUB:  alu_res = ra_val - rb_val;
                default: alu_we  = 1'b0;
            endcase
        end
    end

    // Memory strobes are combinational from the current instruction; gated by
    // RESET so every node shows an idle bus while held in reset.
    assign mem_en    = !RESET && ((is_ld && !ld_pending) || is_sd);
    assign mem_wr_en = !RESET && is_sd;
    assign addr_out  = mem_en ? {16'h0000, imm16} : '0;
    assign d_out     = mem_wr_en ? rd_val : '0;
    assign pc_out    = pc;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc    <= '0;
            state <= ST_EXEC;
            rf    <= '{default: '0};
        end else begin
            case (state)
                ST_EXEC: begin
                    if (is_ld) begin
                        state <= ST_LD_WAIT;
                    end else begin
                        pc <= pc_next;
                        if (alu_we) rf[rd] <= alu_res;
                    end
                end
                ST_LD_WAIT: begin
                    rf[rd] <= d_in;
                    pc     <= pc + 32'd4;
                    state  <= ST_EXEC;
                end
                default: state <= ST_EXEC;
            endcase
        end
    end
endmodule

module cardinal_cmp (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [0:31] node0_inst_in,
    input  logic [0:63] node0_d_in,
    output logic [0:31] node0_pc_out,
    output logic [0:31] node0_addr_out,
    output logic [0:63] node0_d_out,
    output logic        node0_memEn,
    output logic        node0_memWrEn,
    input  logic [0:31] node1_inst_in,
    input  logic [0:63] node1_d_in,
    output logic [0:31] node1_pc_out,
    output logic [0:31] node1_addr_out,
    output logic [0:63] node1_d_out,
    output logic        node1_memEn,
    output logic        node1_memWrEn,
    input  logic [0:31] node2_inst_in,
    input  logic [0:63] node2_d_in,
    output logic [0:31] node2_pc_out,
    output logic [0:31] node2_addr_out,
    output logic [0:63] node2_d_out,
    output logic        node2_memEn,
    output logic        node2_memWrEn,
    input  logic [0:31] node3_inst_in,
    input  logic [0:63] node3_d_in,
    output logic [0:31] node3_pc_out,
    output logic [0:31] node3_addr_out,
    output logic [0:63] node3_d_out,
    output logic        node3_memEn,
    output logic        node3_memWrEn
);
    cardinal_node u_node0 (
        .CLK(CLK), .RESET(RESET), .inst_in(node0_inst_in), .d_in(node0_d_in),
        .pc_out(node0_pc_out), .addr_out(node0_addr_out), .d_out(node0_d_out),
        .mem_en(node0_memEn), .mem_wr_en(node0_memWrEn)
    );
    cardinal_node u_node1 (
        .CLK(CLK), .RESET(RESET), .inst_in(node1_inst_in), .d_in(node1_d_in),
        .pc_out(node1_pc_out), .addr_out(node1_addr_out), .d_out(node1_d_out),
        .mem_en(node1_memEn), .mem_wr_en(node1_memWrEn)
    );
    cardinal_node u_node2 (
        .CLK(CLK), .RESET(RESET), .inst_in(node2_inst_in), .d_in(node2_d_in),
        .pc_out(node2_pc_out), .addr_out(node2_addr_out), .d_out(node2_d_out),
        .mem_en(node2_memEn), .mem_wr_en(node2_memWrEn)
    );
    cardinal_node u_node3 (
        .CLK(CLK), .RESET(RESET), .inst_in(node3_inst_in), .d_in(node3_d_in),
        .pc_out(node3_pc_out), .addr_out(node3_addr_out), .d_out(node3_d_out),
        .mem_en(node3_memEn), .mem_wr_en(node3_memWrEn)
    );
endmodule

module cardinal_cmp_top (
    input  logic        CLK,
    input  logic        RESET,
    output logic [0:31] node0_pc_out,
    output logic [0:31] node0_addr_out,
    output logic [0:63] node0_d_out,
    output logic        node0_memEn,
    output logic        node0_memWrEn,
    output logic [0:31] node1_pc_out,
    output logic [0:31] node1_addr_out,
    output logic [0:63] node1_d_out,
    output logic        node1_memEn,
    output logic        node1_memWrEn,
    output logic [0:31] node2_pc_out,
    output logic [0:31] node2_addr_out,
    output logic [0:63] node2_d_out,
    output logic        node2_memEn,
    output logic        node2_memWrEn,
    output logic [0:31] node3_pc_out,
    output logic [0:31] node3_addr_out,
    output logic [0:63] node3_d_out,
    output logic        node3_memEn,
    output logic        node3_memWrEn
);
    logic [0:31] inst0, inst1, inst2, inst3;
    logic [0:63] rdat0, rdat1, rdat2, rdat3;

    cardinal_cmp u_cmp (
        .CLK(CLK), .RESET(RESET),
        .node0_inst_in(inst0), .node0_d_in(rdat0), .node0_pc_out(node0_pc_out),
        .node0_addr_out(node0_addr_out), .node0_d_out(node0_d_out),
        .node0_memEn(node0_memEn), .node0_memWrEn(node0_memWrEn),
        .node1_inst_in(inst1), .node1_d_in(rdat1), .node1_pc_out(node1_pc_out),
        .node1_addr_out(node1_addr_out), .node1_d_out(node1_d_out),
        .node1_memEn(node1_memEn), .node1_memWrEn(node1_memWrEn),
        .node2_inst_in(inst2), .node2_d_in(rdat2), .node2_pc_out(node2_pc_out),
        .node2_addr_out(node2_addr_out), .node2_d_out(node2_d_out),
        .node2_memEn(node2_memEn), .node2_memWrEn(node2_memWrEn),
        .node3_inst_in(inst3), .node3_d_in(rdat3), .node3_pc_out(node3_pc_out),
        .node3_addr_out(node3_addr_out), .node3_d_out(node3_d_out),
        .node3_memEn(node3_memEn), .node3_memWrEn(node3_memWrEn)
    );

    // Instruction memories index words, so PC[22:29] aliases every 1 KB.
    imem u_imem0 (.memAddr(node0_pc_out[22:29]), .dataOut(inst0));
    imem u_imem1 (.memAddr(node1_pc_out[22:29]), .dataOut(inst1));
    imem u_imem2 (.memAddr(node2_pc_out[22:29]), .dataOut(inst2));
    imem u_imem3 (.memAddr(node3_pc_out[22:29]), .dataOut(inst3));

    dmem u_dmem0 (.clk(CLK), .memEn(node0_memEn), .memWrEn(node0_memWrEn),
                  .memAddr(node0_addr_out[24:31]), .dataIn(node0_d_out), .dataOut(rdat0));
    dmem u_dmem1 (.clk(CLK), .memEn(node1_memEn), .memWrEn(node1_memWrEn),
                  .memAddr(node1_addr_out[24:31]), .dataIn(node1_d_out), .dataOut(rdat1));
    dmem u_dmem2 (.clk(CLK), .memEn(node2_memEn), .memWrEn(node2_memWrEn),
                  .memAddr(node2_addr_out[24:31]), .dataIn(node2_d_out), .dataOut(rdat2));
    dmem u_dmem3 (.clk(CLK), .memEn(node3_memEn), .memWrEn(node3_memWrEn),
                  .memAddr(node3_addr_out[24:31]), .dataIn(node3_d_out), .dataOut(rdat3));
endmodule

// File: tb/tb_cardinal_cmp_top.sv
// Directed bench for cardinal_cmp_top: stores are checked by a scoreboard monitor,
// PC timing and memory contents by the stimulus process.

module tb_cardinal_cmp_top;
    logic CLK = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    logic [0:31] node0_pc_out, node1_pc_out, node2_pc_out, node3_pc_out;
    logic [0:31] node0_addr_out, node1_addr_out, node2_addr_out, node3_addr_out;
    logic [0:63] node0_d_out, node1_d_out, node2_d_out, node3_d_out;
    logic        node0_memEn, node1_memEn, node2_memEn, node3_memEn;
    logic        node0_memWrEn, node1_memWrEn, node2_memWrEn, node3_memWrEn;

    cardinal_cmp_top dut (
        .CLK(CLK), .RESET(RESET),
        .node0_pc_out(node0_pc_out), .node0_addr_out(node0_addr_out), .node0_d_out(node0_d_out),
        .node0_memEn(node0_memEn), .node0_memWrEn(node0_memWrEn),
        .node1_pc_out(node1_pc_out), .node1_addr_out(node1_addr_out), .node1_d_out(node1_d_out),
        .node1_memEn(node1_memEn), .node1_memWrEn(node1_memWrEn),
        .node2_pc_out(node2_pc_out), .node2_addr_out(node2_addr_out), .node2_d_out(node2_d_out),
        .node2_memEn(node2_memEn), .node2_memWrEn(node2_memWrEn),
        .node3_pc_out(node3_pc_out), .node3_addr_out(node3_addr_out), .node3_d_out(node3_d_out),
        .node3_memEn(node3_memEn), .node3_memWrEn(node3_memWrEn)
    );

    logic [0:31] pc_o [4];
    logic [0:31] ao_o [4];
    logic [0:63] do_o [4];
    logic        men  [4];
    logic        mwe  [4];

    assign pc_o[0] = node0_pc_out;   assign pc_o[1] = node1_pc_out;
    assign pc_o[2] = node2_pc_out;   assign pc_o[3] = node3_pc_out;
    assign ao_o[0] = node0_addr_out; assign ao_o[1] = node1_addr_out;
    assign ao_o[2] = node2_addr_out; assign ao_o[3] = node3_addr_out;
    assign do_o[0] = node0_d_out;    assign do_o[1] = node1_d_out;
    assign do_o[2] = node2_d_out;    assign do_o[3] = node3_d_out;
    assign men[0]  = node0_memEn;    assign men[1]  = node1_memEn;
    assign men[2]  = node2_memEn;    assign men[3]  = node3_memEn;
    assign mwe[0]  = node0_memWrEn;  assign mwe[1]  = node1_memWrEn;
    assign mwe[2]  = node2_memWrEn;  assign mwe[3]  = node3_memWrEn;

    typedef struct {
        logic [0:31] addr;
        logic [0:63] data;
    } st_t;

    st_t q [4][$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [0:63] act, input logic [0:63] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic exp_st(input logic [1:0] n, input logic [0:31] a, input logic [0:63] d);
        st_t e;
        e.addr = a;
        e.data = d;
        q[n].push_back(e);
    endtask

    task automatic set_i(input logic [1:0] n, input logic [0:7] a, input logic [0:31] w);
        case (n)
            2'd0: dut.u_imem0.MEM[a] = w;
            2'd1: dut.u_imem1.MEM[a] = w;
            2'd2: dut.u_imem2.MEM[a] = w;
            default: dut.u_imem3.MEM[a] = w;
        endcase
    endtask

    task automatic set_d(input logic [1:0] n, input logic [0:7] a, input logic [0:63] w);
        case (n)
            2'd0: dut.u_dmem0.MEM[a] = w;
            2'd1: dut.u_dmem1.MEM[a] = w;
            2'd2: dut.u_dmem2.MEM[a] = w;
            default: dut.u_dmem3.MEM[a] = w;
        endcase
    endtask

    function automatic logic [0:63] get_d(input logic [1:0] n, input logic [0:7] a);
        case (n)
            2'd0: return dut.u_dmem0.MEM[a];
            2'd1: return dut.u_dmem1.MEM[a];
            2'd2: return dut.u_dmem2.MEM[a];
            default: return dut.u_dmem3.MEM[a];
        endcase
    endfunction

    task automatic clear_imem();
        for (int a = 0; a < 256; a++)
            for (int n = 0; n < 4; n++) set_i(n[1:0], a[7:0], 32'h00000000);
    endtask

    // Store monitor: every write strobe must match the next expected store of that node.
    always @(negedge CLK) begin
        st_t e;
        for (int n = 0; n < 4; n++) begin
            if (men[n[1:0]] && mwe[n[1:0]]) begin
                checks++;
                if (q[n[1:0]].size() == 0) begin
                    errors++;
                    $display("FAIL store_n%0d unexpected addr %h data %h required no store",
                             n, ao_o[n[1:0]], do_o[n[1:0]]);
                end else begin
                    e = q[n[1:0]].pop_front();
                    if (ao_o[n[1:0]] !== e.addr || do_o[n[1:0]] !== e.data) begin
                        errors++;
                        $display("FAIL store_n%0d actual addr %h data %h required addr %h data %h",
                                 n, ao_o[n[1:0]], do_o[n[1:0]], e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    int nop_cyc;

    initial begin
        RESET = 1'b1;
        clear_imem();
        for (int a = 0; a < 256; a++)
            for (int n = 0; n < 4; n++) set_d(n[1:0], a[7:0], 64'h0);

        // Reset values and NOP sequencing after release
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("rst_pc_n%0d", n), {32'h0, pc_o[n[1:0]]}, 64'h0);
            chk($sformatf("rst_memEn_n%0d", n), {63'h0, men[n[1:0]]}, 64'h0);
            chk($sformatf("rst_memWrEn_n%0d", n), {63'h0, mwe[n[1:0]]}, 64'h0);
        end
        @(posedge CLK);
        #1 RESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            for (int n = 0; n < 4; n++)
                chk($sformatf("nop_pc_n%0d_c%0d", n, c), {32'h0, pc_o[n[1:0]]}, 64'(4 * c));
        end

        // Four independent programs at once
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        clear_imem();
        set_d(0, 0, 64'd5); set_d(0, 1, 64'd7);
        set_i(0, 0, 32'h80200000); set_i(0, 1, 32'h80400001);
        set_i(0, 2, 32'hA8611006); set_i(0, 3, 32'h84600002);
        exp_st(0, 32'd2, 64'h000000000000000C);

        set_d(1, 0, 64'd0); set_d(1, 1, 64'd1);
        set_i(1, 0, 32'h80200000); set_i(1, 1, 32'h80400001);
        set_i(1, 2, 32'hA8611007); set_i(1, 3, 32'h84600002);
        exp_st(1, 32'd2, 64'hFFFFFFFFFFFFFFFF);

        set_d(2, 0, 64'hAA);
        set_i(2, 0, 32'h88000010);  // BEZ R0 -> 0x10
        set_i(2, 1, 32'h84000001);  // skipped
        set_i(2, 4, 32'h8C000040);  // BNEZ R0 falls through
        set_i(2, 5, 32'h80200000); set_i(2, 6, 32'h84200002);
        set_i(2, 7, 32'h84000002);  // overwrite same address
        set_i(2, 8, 32'h8C200040);  // BNEZ R1 taken -> 0x40
        set_i(2, 9, 32'h84000009);  // skipped
        set_i(2, 16, 32'h84200003);
        exp_st(2, 32'd2, 64'hAA);
        exp_st(2, 32'd2, 64'h0);
        exp_st(2, 32'd3, 64'hAA);

        set_d(3, 0, 64'hF0F0F0F0F0F0F0F0); set_d(3, 1, 64'h00FF00FF00FF00FF);
        set_i(3, 0, 32'h80200000);  set_i(3, 1, 32'h80400001);
        set_i(3, 2, 32'hA8611003);  set_i(3, 3, 32'h84600004);
        set_i(3, 4, 32'hA8811002);  set_i(3, 5, 32'h84800005);
        set_i(3, 6, 32'hA8A11001);  set_i(3, 7, 32'h84A00006);
        set_i(3, 8, 32'hA8C10004);  set_i(3, 9, 32'h84C00007);
        set_i(3, 10, 32'hA8E20005); set_i(3, 11, 32'h84E00008);
        set_i(3, 12, 32'hA8E1003F); set_i(3, 13, 32'h84E00009);
        exp_st(3, 32'd4, 64'hF00FF00FF00FF00F);
        exp_st(3, 32'd5, 64'hF0FFF0FFF0FFF0FF);
        exp_st(3, 32'd6, 64'h00F000F000F000F0);
        exp_st(3, 32'd7, 64'h0F0F0F0F0F0F0F0F);
        exp_st(3, 32'd8, 64'h00FF00FF00FF00FF);
        exp_st(3, 32'd9, 64'h00FF00FF00FF00FF);

        for (int n = 0; n < 3; n++) set_d(n[1:0], 8'd4, 64'h5A5A5A5A5A5A5A5A);

        @(posedge CLK);
        #1 RESET = 1'b0;
        nop_cyc = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (nop_cyc < 0 && pc_o[0] == 32'h10) nop_cyc = c;
            if (c == 0) chk("bez_pc_c0", {32'h0, pc_o[2]}, 64'h00);
            if (c == 1) chk("bez_taken_pc", {32'h0, pc_o[2]}, 64'h10);
            if (c == 2) chk("bnez_untaken_pc", {32'h0, pc_o[2]}, 64'h14);
            if (c == 1) chk("ld_hold_pc_n1", {32'h0, pc_o[1]}, 64'h0);
            if (c == 2) chk("ld_done_pc_n1", {32'h0, pc_o[1]}, 64'h4);
        end
        chk("nop_reach_cycle", 64'(nop_cyc), 64'd6);
        chk("dmem0_2", get_d(0, 2), 64'h000000000000000C);
        chk("dmem1_2", get_d(1, 2), 64'hFFFFFFFFFFFFFFFF);
        chk("dmem2_2_last_sd", get_d(2, 2), 64'h0);
        chk("dmem2_3", get_d(2, 3), 64'hAA);
        chk("dmem3_9_badfunc", get_d(3, 9), 64'h00FF00FF00FF00FF);
        for (int n = 0; n < 3; n++)
            chk($sformatf("dmem%0d_4_untouched", n), get_d(n[1:0], 8'd4), 64'h5A5A5A5A5A5A5A5A);
        for (int n = 0; n < 4; n++)
            chk($sformatf("store_missing_n%0d", n), 64'(q[n[1:0]].size()), 64'd0);

        // Reset arriving in the second cycle of a load
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        clear_imem();
        set_i(0, 0, 32'h80200000);
        set_d(0, 0, 64'd5);
        set_d(0, 3, 64'hDEADBEEFDEADBEEF);
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("ld_c1_memEn", {63'h0, men[0]}, 64'h1);
        chk("ld_c1_addr", {32'h0, ao_o[0]}, 64'h0);
        @(posedge CLK);
        #1;
        chk("ld_c2_memEn", {63'h0, men[0]}, 64'h0);
        chk("ld_c2_pc", {32'h0, pc_o[0]}, 64'h0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("ld_abort_pc", {32'h0, pc_o[0]}, 64'h0);
        set_i(0, 0, 32'h84200003);  // SD R1,3 exposes R1
        exp_st(0, 32'd3, 64'h0);
        RESET = 1'b0;
        for (int c = 0; c < 10 && q[0].size() != 0; c++) @(negedge CLK);
        @(negedge CLK);
        chk("ld_abort_store_seen", 64'(q[0].size()), 64'd0);
        chk("ld_abort_r1", get_d(0, 3), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
